// File: rtl/bitmap_alloc.sv
// Free-slot bitmap allocator: grants the lowest free slot, accepts one release per cycle,
// and keeps registered occupancy status (count, all/none free, sticky double-free error).
module bitmap_alloc #(
    parameter int N     = 32,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    output logic             alloc_gnt,
    output logic [IDX_W-1:0] alloc_idx,
    input  logic             free_valid,
    input  logic [IDX_W-1:0] free_idx,
    input  logic             flush,
    output logic [N-1:0]     bitmap,
    output logic [IDX_W:0]   free_count,
    output logic             all_free,
    output logic             none_free,
    output logic             err_double_free
);

    logic [N-1:0]     bitmap_d;
    logic [IDX_W:0]   count_d;
    logic             any_free;
    logic             free_in_range;
    logic             free_hits_free;
    logic             rel_ok;
    logic             dbl_free;

    // An index port of exactly IDX_W bits can only exceed N-1 when N is not a power of two.
    if (N == (1 << IDX_W)) begin : g_pow2
        assign free_in_range = 1'b1;
    end else begin : g_npow2
        assign free_in_range = ({1'b0, free_idx} < (IDX_W+1)'(N));
    end

    // Lowest-indexed set bit; scanning downward lets the last hit win.
    always_comb begin
        alloc_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bitmap[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
    end

    assign any_free  = |bitmap;
    assign alloc_gnt = alloc_req & ~flush & ~rst & any_free;

    always_comb begin
        free_hits_free = 1'b0;
        if (free_in_range) begin
            free_hits_free = bitmap[free_idx];
        end
    end

    assign dbl_free = free_valid & ~flush & (~free_in_range | free_hits_free);
    assign rel_ok   = free_valid & ~flush & free_in_range & ~free_hits_free;

    always_comb begin
        bitmap_d = bitmap;
        count_d  = free_count;
        if (flush) begin
            bitmap_d = '1;
            count_d  = (IDX_W+1)'(N);
        end else begin
            if (alloc_gnt) begin
                bitmap_d[alloc_idx] = 1'b0;
            end
            if (rel_ok) begin
                bitmap_d[free_idx] = 1'b1;
            end
            count_d = free_count - (IDX_W+1)'(alloc_gnt) + (IDX_W+1)'(rel_ok);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitmap          <= '1;
            free_count      <= (IDX_W+1)'(N);
            all_free        <= 1'b1;
            none_free       <= 1'b0;
            err_double_free <= 1'b0;
        end else begin
            bitmap          <= bitmap_d;
            free_count      <= count_d;
            all_free        <= &bitmap_d;
            none_free       <= ~|bitmap_d;
            if (dbl_free) begin
                err_double_free <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bitmap_alloc.sv
// Scoreboard bench for bitmap_alloc: stimulus pushes model expectations, a monitor checks them.
module tb_bitmap_alloc;

    localparam int N     = 32;
    localparam int IDX_W = 5;

    logic             clk;
    logic             rst;
    logic             alloc_req;
    logic             alloc_gnt;
    logic [IDX_W-1:0] alloc_idx;
    logic             free_valid;
    logic [IDX_W-1:0] free_idx;
    logic             flush;
    logic [N-1:0]     bitmap;
    logic [IDX_W:0]   free_count;
    logic             all_free;
    logic             none_free;
    logic             err_double_free;

    bitmap_alloc #(.N(N), .IDX_W(IDX_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_req       (alloc_req),
        .alloc_gnt       (alloc_gnt),
        .alloc_idx       (alloc_idx),
        .free_valid      (free_valid),
        .free_idx        (free_idx),
        .flush           (flush),
        .bitmap          (bitmap),
        .free_count      (free_count),
        .all_free        (all_free),
        .none_free       (none_free),
        .err_double_free (err_double_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        int          idx;
        logic [31:0] bm;
        int          cnt;
        logic        af;
        logic        nf;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: per-slot free flags and the sticky error.
    bit   m_free[N];
    bit   m_err;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_free[i] = 1'b1;
        m_err = 1'b0;
    endtask

    // One cycle of stimulus; the model derives the expected response from slot semantics.
    task automatic cycle(input bit req, input bit fv, input int fidx, input bit fl);
        exp_t e;
        int   lowest;
        int   cnt;
        bit   dbl;
        @(negedge clk);
        alloc_req  = req;
        free_valid = fv;
        free_idx   = IDX_W'(fidx);
        flush      = fl;
        lowest = -1;
        for (int i = N - 1; i >= 0; i--) if (m_free[i]) lowest = i;
        e.gnt = req && !fl && (lowest >= 0);
        e.idx = (lowest >= 0) ? lowest : 0;
        if (fl) begin
            for (int i = 0; i < N; i++) m_free[i] = 1'b1;
        end else begin
            dbl = fv && m_free[fidx];
            if (e.gnt) m_free[lowest] = 1'b0;
            if (fv && dbl) m_err = 1'b1;
            if (fv && !dbl) m_free[fidx] = 1'b1;
        end
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            e.bm[i] = m_free[i];
            cnt += int'(m_free[i]);
        end
        e.cnt = cnt;
        e.af  = (cnt == N);
        e.nf  = (cnt == 0);
        e.err = m_err;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        alloc_req = 1'b0; free_valid = 1'b0; flush = 1'b0; free_idx = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: combinational grant checked mid-cycle, registered state just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("alloc_gnt", alloc_gnt, e.gnt);
                if (e.gnt) check("alloc_idx", alloc_idx, e.idx);
                @(posedge clk);
                #1;
                check("bitmap", bitmap, e.bm);
                check("free_count", free_count, e.cnt);
                check("all_free", all_free, e.af);
                check("none_free", none_free, e.nf);
                check("err_double_free", err_double_free, e.err);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int wait_cycles;
        rst = 1'b1;
        alloc_req = 1'b0; free_valid = 1'b0; flush = 1'b0; free_idx = '0;
        model_reset();
        #12;
        check("reset_bitmap", bitmap, 32'hFFFF_FFFF);
        check("reset_count", free_count, N);
        check("reset_all_free", all_free, 1);
        check("reset_none_free", none_free, 0);
        check("reset_err", err_double_free, 0);
        check("reset_gnt", alloc_gnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // Fill all slots, then one request too many.
        for (int i = 0; i < N; i++) cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        // Release slot 7 while requesting: no bypass; next cycle slot 7 is granted.
        cycle(1, 1, 7, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 1);
        // Slots 0..3 held, then concurrent alloc and release of slot 1.
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
        cycle(1, 1, 1, 0);
        cycle(0, 0, 0, 0);
        // Double free right after reset is sticky.
        do_reset();
        cycle(0, 1, 5, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        // Flush overrides release and grant, records no error.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0);
        cycle(1, 1, 2, 1);
        cycle(0, 0, 0, 0);

        // Randomized traffic, biased so occupancy wanders across the full range.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
                  int'($urandom_range(0, N - 1)), ($urandom_range(0, 99) < 2));
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 50) begin
            @(posedge clk);
            wait_cycles++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        // Asynchronous reset mid-cycle with 20 slots held.
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0);
        @(negedge clk);
        alloc_req = 1'b0;
        @(posedge clk);
        #3;
        check("pre_async_count", free_count, N - 20);
        rst = 1'b1;
        #1;
        check("async_bitmap", bitmap, 32'hFFFF_FFFF);
        check("async_count", free_count, N);
        check("async_all_free", all_free, 1);
        check("async_gnt", alloc_gnt, 0);
        @(negedge clk);
        rst = 1'b0;
        #20;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitmap_alloc.md
Name: bitmap_alloc

Overview:
- Free-slot bitmap allocator for the OOO core: tracks N slots (ROB/physical-register/IQ tags); a set bit marks a free slot.
- Grants the lowest-indexed free slot on request and accepts one release per cycle.
- Acts as the write/update side of the bitmap: it maintains the vector whose AND-reduction is the "all slots free" indication, and drives that indication as a registered status flag.
- Sits between rename/dispatch (allocation) and commit/writeback (release).

Parameters:
- N, 32, number of slots (power of two, 2..64).
- IDX_W, $clog2(N), slot index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- alloc_req  in  1  request one free slot this cycle.
- alloc_gnt  out  1  grant; combinational; equals alloc_req & ~flush & (bitmap != 0).
- alloc_idx  out  IDX_W  lowest-indexed free slot; combinational; 0 when no slot is free.
- free_valid  in  1  release slot free_idx this cycle.
- free_idx  in  IDX_W  slot to release.
- flush  in  1  release all slots (pipeline flush).
- bitmap  out  N  registered free bitmap; bit i = 1 means slot i is free.
- free_count  out  IDX_W+1  registered count of free slots.
- all_free  out  1  registered; 1 when every bitmap bit is 1 (AND-reduction of bitmap).
- none_free  out  1  registered; 1 when bitmap == 0.
- err_double_free  out  1  sticky; set when a release targets an already-free slot.

Behaviour:
- Reset (async, while rst=1):
  - bitmap = all ones; free_count = N.
  - all_free = 1, none_free = 0, err_double_free = 0.
  - alloc_gnt = 0 while rst is high.
- Allocation:
  - A grant is issued in the same cycle as the request; there is no backpressure beyond alloc_gnt.
  - On a clock edge with alloc_gnt=1, bitmap[alloc_idx] is cleared.
  - Priority encoder picks the lowest set bit; alloc_idx is stable for the whole cycle.
- Release:
  - On a clock edge with free_valid=1 and ~flush, bitmap[free_idx] is set.
  - If bitmap[free_idx] is already 1: the bitmap is unchanged, free_count is unchanged, and err_double_free is set (cleared only by rst).
  - A free_idx >= N is treated as a double free and otherwise ignored.
- Release-to-allocate latency is 1 cycle. A slot released in cycle t is first grantable in cycle t+1; there is no same-cycle bypass.
- Simultaneous alloc and free of different slots: both apply, and free_count is unchanged.
- Alloc and free never target the same slot in one cycle. Alloc only picks free slots; freeing a free slot is a double free, so the free is discarded and the alloc still applies.
- free_count arithmetic: next = count − alloc_gnt + valid_release. It saturates logically within 0..N; no wrap is ever possible given the rules above.
- all_free / none_free:
  - Both are computed from the next bitmap and registered, so they match bitmap in the same cycle.
  - all_free == (free_count == N); none_free == (free_count == 0).
- Flush:
  - On an edge with flush=1, bitmap = all ones and free_count = N.
  - Flush overrides free_valid; alloc_gnt is forced to 0 during flush.
  - No double-free error is recorded in a flush cycle.
- Full condition: with bitmap == 0, alloc_req gives alloc_gnt=0 and alloc_idx=0, and state is unchanged. A same-cycle release still applies.
- Reset asserted mid-operation: state returns immediately to reset values, and pending requests in that cycle are lost.

Test Plan:
- Reset then 32 consecutive cycles of alloc_req=1 -> alloc_idx = 0,1,...,31 with alloc_gnt=1 each cycle. Afterwards bitmap=0, free_count=0, none_free=1. A 33rd request gives alloc_gnt=0.
- From full: free_idx=7, then next cycle alloc_req=1 -> alloc_idx=7, alloc_gnt=1. In the free cycle itself, alloc_req gives alloc_gnt=0 (no bypass).
- Slots 0..3 allocated; same cycle alloc_req=1 and free_idx=1 -> alloc grants 4. Next cycle bitmap[1]=1, bitmap[4]=0, free_count unchanged at 28.
- After reset, free_valid with free_idx=5 -> err_double_free=1 and stays 1. bitmap stays all ones, free_count=32, all_free=1.
- 10 slots allocated, then flush=1 with alloc_req=1 and free_idx=2 -> alloc_gnt=0. Next cycle bitmap=0xFFFFFFFF, free_count=32, all_free=1, err_double_free still 0.
- rst asserted asynchronously mid-cycle with 20 slots allocated -> bitmap all ones and free_count=32 immediately, without waiting for a clock edge.
